// File: rtl/spi_slave_10.sv
// SPI mode-0 slave, MSB first, 8-bit words, with sck/ss/mosi oversampled in the clk domain.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN releases miso to high-Z outside a frame.
module spi_slave_10 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  input  logic [7:0] data_in,
  output logic       miso,
  output logic       busy,
  output logic       new_data,
  output logic [7:0] data_out
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  // Index 0 samples the pin; index SYNC_STAGES is the history flop for edge detection.
  logic [SYNC_STAGES:0] ss_sr, sck_sr, mosi_sr;
  logic                 armed;
  logic [2:0]           bit_cnt;
  logic [7:0]           tx_shift, rx_shift;

  logic ss_rise, ss_fall, sck_rise, sck_fall, mosi_s, start;

  // NOTE: non-blocking assignments for every flop so all stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sr   <= '1;
      sck_sr  <= '0;
      mosi_sr <= '0;
    end else begin
      ss_sr   <= {ss_sr[SYNC_STAGES-1:0], ss};
      sck_sr  <= {sck_sr[SYNC_STAGES-1:0], sck};
      mosi_sr <= {mosi_sr[SYNC_STAGES-1:0], mosi};
    end
  end

  assign ss_fall  =  ss_sr[SYNC_STAGES]  & ~ss_sr[SYNC_STAGES-1];
  assign ss_rise  = ~ss_sr[SYNC_STAGES]  &  ss_sr[SYNC_STAGES-1];
  assign sck_rise = ~sck_sr[SYNC_STAGES] &  sck_sr[SYNC_STAGES-1];
  assign sck_fall =  sck_sr[SYNC_STAGES] & ~sck_sr[SYNC_STAGES-1];
  assign mosi_s   =  mosi_sr[SYNC_STAGES-1];

  // A frame may only start after ss has been seen high since reset, so an ss held
  // low through reset release does not open a frame halfway through a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          armed <= 1'b0;
    else if (ss_sr[0]) armed <= 1'b1;
  end

  assign start = (state_q == IDLE) && ss_fall && armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      data_out <= 8'h00;
      new_data <= 1'b0;
    end else begin
      new_data <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          bit_cnt  <= 3'd0;
          tx_shift <= data_in;
        end
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_out <= {rx_shift[6:0], mosi_s};
            new_data <= 1'b1;
            tx_shift <= data_in;
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          // bit_cnt == 0 means the word was just reloaded; keep its MSB on the line.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        // A partial byte is dropped on deselect; a completing byte above still lands.
        if (ss_rise) bit_cnt <= 3'd0;
      end
    end
  end

  assign busy = (state_q == ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = busy ? tx_shift[7] : 1'bz;
`else
  assign miso = busy ? tx_shift[7] : 1'b1;
`endif

endmodule
